// File: rtl/rom_byte_streamer.sv
// Streams a range of 16-bit table-ROM words as bytes (high byte first) on a valid/ready port.
// Optional build macro ROM_SELFTEST_EN adds a sticky selftest_err check against the identity table.
module rom_byte_streamer #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_dout,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
`ifdef ROM_SELFTEST_EN
  output logic              selftest_err,
`endif
  output logic [2:0]        dbg_state
);

  // Byte stream: a byte moves when m_valid && m_ready at a rising edge; once m_valid
  // is high, m_data/m_last/rom_addr hold until that handshake.
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_HI, S_LO} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic [15:0]         r_word_q, w_word_q_nxt;
  logic [CNT_W-1:0]    r_remaining, w_remaining_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_word_q    <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_word_q    <= w_word_q_nxt;
      r_remaining <= w_remaining_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rom_addr_nxt  = r_rom_addr;
    w_word_q_nxt    = r_word_q;
    w_remaining_nxt = r_remaining;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            w_rom_addr_nxt  = first_addr;
            w_remaining_nxt = num_words - CNT_W'(1);
            w_busy_nxt      = 1'b1;
            w_state_nxt     = S_WAIT;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_WAIT: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_word_q_nxt = rom_dout;
        w_capture    = 1'b1;
        if (r_remaining != '0) w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
        w_state_nxt  = S_HI;
      end
      S_HI: begin
        if (m_ready) w_state_nxt = S_LO;
      end
      S_LO: begin
        if (m_ready) begin
          if (r_remaining == '0) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            // The next word's address was issued at least two edges ago, so rom_dout is settled.
            w_word_q_nxt    = rom_dout;
            w_capture       = 1'b1;
            w_remaining_nxt = r_remaining - CNT_W'(1);
            if (r_remaining != CNT_W'(1)) w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
            w_state_nxt     = S_HI;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_data = 8'h00;
    case (r_state)
      S_HI:    m_data = r_word_q[15:8];
      S_LO:    m_data = r_word_q[7:0];
      default: m_data = 8'h00;
    endcase
  end

  assign m_valid   = (r_state == S_HI) || (r_state == S_LO);
  assign m_last    = (r_state == S_LO) && (r_remaining == '0);
  assign busy      = r_busy;
  assign done      = r_done;
  assign rom_addr  = r_rom_addr;
  assign dbg_state = r_state;

`ifdef ROM_SELFTEST_EN
  // Every captured word was read from the current rom_addr; expected content is {2a, 2a+1}.
  logic [7:0] w_exp_hi;
  logic       r_selftest_err;
  assign w_exp_hi = 8'({r_rom_addr, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_selftest_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_selftest_err <= 1'b0;
    end else if (w_capture && (rom_dout != {w_exp_hi, w_exp_hi + 8'd1})) begin
      r_selftest_err <= 1'b1;
    end
  end

  assign selftest_err = r_selftest_err;
`endif

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Directed bench for rom_byte_streamer with a registered identity-table ROM model.
// Build with ROM_SELFTEST_EN defined to also exercise the selftest_err output.
module tb_rom_byte_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  first_addr;
  logic [7:0]  num_words;
  logic        busy;
  logic        done;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic [2:0]  dbg_state;
`ifdef ROM_SELFTEST_EN
  logic        selftest_err;
`endif

  logic [15:0] mem [128];
  logic [7:0]  exp_q [$];
  int          n_cmp;
  int          n_err;
  int          hs;
  int          cyc;

  rom_byte_streamer #(.ADDR_W(7), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr),
    .num_words(num_words), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready),
`ifdef ROM_SELFTEST_EN
    .selftest_err(selftest_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / ROM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_dout <= mem[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [6:0] a, input logic [7:0] n);
    first_addr = a;
    num_words  = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Drains exp_q through the byte port; toggle=1 drives m_ready as 1,0,0,1,0,0,...
  task automatic run_stream(input string tag, input bit toggle, input bit last_final,
                            output int n_hs, output int n_cyc);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [6:0] prev_addr;
    logic [7:0] exp_b;
    int         i;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_addr  = '0;
    n_hs  = 0;
    n_cyc = 0;
    i     = 0;
    while (exp_q.size() > 0 && i < 200) begin
      m_ready = toggle ? ((i % 3) == 0) : 1'b1;
      #0;
      if (prev_stall) begin
        check({tag, "_valid_held"}, 32'(m_valid), 32'd1);
        check({tag, "_data_held"}, 32'(m_data), 32'(prev_data));
        check({tag, "_addr_held"}, 32'(rom_addr), 32'(prev_addr));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_addr  = rom_addr;
      if (m_valid && m_ready) begin
        exp_b = exp_q.pop_front();
        check({tag, "_data"}, 32'(m_data), 32'(exp_b));
        check({tag, "_last"}, 32'(m_last), 32'(last_final && (exp_q.size() == 0)));
        n_hs++;
      end
      step();
      n_cyc++;
      i++;
    end
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] hi;
    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 128; a++) begin
      hi     = 8'(a * 2);
      mem[a] = {hi, hi + 8'd1};
    end
    rst_n = 1'b0; start = 1'b0; first_addr = '0; num_words = '0; m_ready = 1'b1;

    // reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // two words from 0: latency 3 cycles, then back-to-back bytes
    start_run(7'h00, 8'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_c1", 32'(m_valid), 32'd0);
    step();
    check("t1_valid_c2", 32'(m_valid), 32'd0);
    step();
    check("t1_valid_c3", 32'(m_valid), 32'd1);
    check("t1_first", 32'(m_data), 32'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    run_stream("t1", 1'b0, 1'b1, hs, cyc);
    check("t1_cycles", 32'(cyc), 32'd4);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_valid_end", 32'(m_valid), 32'd0);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);

    // address wrap 7F -> 00
    start_run(7'h7E, 8'd3);
    step();
    step();
    check("t2_addr_7f", 32'(rom_addr), 32'h7F);
    exp_q.push_back(8'hFC); exp_q.push_back(8'hFD); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    run_stream("t2", 1'b0, 1'b1, hs, cyc);
    check("t2_addr_wrap", 32'(rom_addr), 32'h00);
    check("t2_done", 32'(done), 32'd1);
    step();

    // backpressure
    start_run(7'h04, 8'd4);
    for (int b = 8; b < 16; b++) exp_q.push_back(8'(b));
    run_stream("t3", 1'b1, 1'b1, hs, cyc);
    check("t3_handshakes", 32'(hs), 32'd8);
    check("t3_done", 32'(done), 32'd1);
    step();

    // empty run
    start_run(7'h10, 8'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(m_valid), 32'd0);
    step();
    check("t4_done_pulse", 32'(done), 32'd0);
    check("t4_busy2", 32'(busy), 32'd0);
    check("t4_valid2", 32'(m_valid), 32'd0);

    // start while busy is ignored
    start_run(7'h10, 8'd2);
    first_addr = 7'h40; num_words = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    run_stream("t5", 1'b0, 1'b1, hs, cyc);
    check("t5_handshakes", 32'(hs), 32'd4);
    check("t5_done", 32'(done), 32'd1);
    step();
    step();
    check("t5_idle_valid", 32'(m_valid), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);

    // reset during the third byte
    start_run(7'h20, 8'd3);
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    run_stream("t6", 1'b0, 1'b0, hs, cyc);
    check("t6_third_valid", 32'(m_valid), 32'd1);
    check("t6_third_data", 32'(m_data), 32'h42);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(rom_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_no_done", 32'(done), 32'd0);
    check("t6_no_resume", 32'(m_valid), 32'd0);
    start_run(7'h30, 8'd1);
    exp_q.push_back(8'h60); exp_q.push_back(8'h61);
    run_stream("t6b", 1'b0, 1'b1, hs, cyc);
    check("t6b_done", 32'(done), 32'd1);
    step();

`ifdef ROM_SELFTEST_EN
    // corrupted word at 0x05
    mem[5] = 16'hFFFF;
    start_run(7'h04, 8'd3);
    check("st_err_clear", 32'(selftest_err), 32'd0);
    step();
    step();
    check("st_err_after_w4", 32'(selftest_err), 32'd0);
    exp_q.push_back(8'h08); exp_q.push_back(8'h09); exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
    run_stream("st", 1'b0, 1'b1, hs, cyc);
    check("st_err_set", 32'(selftest_err), 32'd1);
    step();
    check("st_err_sticky", 32'(selftest_err), 32'd1);
    mem[5] = 16'h0A0B;
    start_run(7'h00, 8'd1);
    check("st_err_cleared", 32'(selftest_err), 32'd0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    run_stream("st2", 1'b0, 1'b1, hs, cyc);
    check("st2_err", 32'(selftest_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_byte_streamer.md
Name: rom_byte_streamer

Overview:
- Reader/consumer end of the 128x16 constant table ROMs used by the crypto datapath. The ROMs have a 7-bit address, a registered 16-bit output, and one-cycle read latency.
- Walks a programmed address range, unpacks each 16-bit word into two bytes (high byte first), and emits them on a valid/ready byte stream.
- Sits between a table ROM instance and the downstream hash/sampler input FIFO. Sustains 1 byte/cycle after a single initial latency bubble.

Parameters:
- ADDR_W, 7, ROM address width; table depth is 2**ADDR_W words.
- CNT_W, 8, width of the word-count input; must be at least ADDR_W+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- first_addr  in  ADDR_W  first ROM word address.
- num_words  in  CNT_W  number of words to stream; 0 means an empty run.
- busy  out  1  high from the cycle after an accepted start until the run completes.
- done  out  1  one-cycle pulse when a run completes.
- rom_addr  out  ADDR_W  address to the ROM; driven from a register.
- rom_dout  in  16  ROM registered output; valid one cycle after rom_addr changes.
- m_valid  out  1  output byte valid.
- m_data  out  8  output byte.
- m_last  out  1  marks the final byte of the run; qualified by m_valid.
- m_ready  in  1  downstream ready.

Behaviour:
- Reset values (asynchronous, all outputs and state): state=IDLE, rom_addr=0, word_q=0, remaining=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
- States: IDLE, WAIT, LOAD, HI, LO.
- IDLE
  - start with num_words>0: rom_addr<=first_addr, remaining<=num_words-1, busy<=1, go to WAIT.
  - start with num_words==0: done pulses next cycle, busy stays 0, stay in IDLE.
- WAIT: one cycle to cover ROM latency; go to LOAD.
- LOAD
  - word_q<=rom_dout.
  - If remaining!=0: rom_addr<=rom_addr+1, modulo 2**ADDR_W (0x7F wraps to 0x00).
  - Go to HI.
- HI
  - m_valid=1, m_data=word_q[15:8], m_last=0.
  - On m_valid&&m_ready: go to LO.
- LO
  - m_valid=1, m_data=word_q[7:0], m_last=(remaining==0).
  - Handshake with remaining==0: m_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - Handshake with remaining!=0: word_q<=rom_dout, remaining<=remaining-1, rom_addr<=rom_addr+1 if the decremented remaining !=0, go to HI. This is a no-bubble prefetch: rom_addr changed at least two edges earlier, so rom_dout is settled.
- Backpressure: while m_valid=1 and m_ready=0, m_data, m_last and rom_addr hold stable. No byte is dropped or duplicated.
- m_valid never deasserts without a handshake, except on reset.
- start while busy is ignored and the run continues unchanged.
- num_words above 2**ADDR_W keeps wrapping and re-reads the table; the word count is honoured exactly.
- Byte latency: first byte m_valid rises 3 cycles after the start cycle (IDLE->WAIT->LOAD->HI).
- Throughput: 1 byte/cycle thereafter with m_ready held high.
- rst_n asserted mid-run: immediate return to reset values. No done pulse, and no partial run resumes after reset.

Optional Feature:
- Macro: ROM_SELFTEST_EN.
- Defined:
  - Adds output port selftest_err (1 bit, reset 0).
  - At every word capture (LOAD, and the LO prefetch), the captured word is compared with {2a[7:0], 2a[7:0]+1}, where a is the address the word was read from.
  - Any mismatch sets selftest_err, which stays sticky until reset or the next accepted start.
  - The stream itself is unaffected.
- Undefined: the port and comparison logic are absent; behaviour is otherwise identical.

Test Plan:
- Identity table, first_addr=0, num_words=2, m_ready=1 -> bytes 00,01,02,03 on consecutive cycles; m_last only on 03; done pulses one cycle after the 03 handshake; first m_valid 3 cycles after start.
- first_addr=0x7E, num_words=3 -> bytes FC,FD,FE,FF,00,01; rom_addr wraps 7F->00; m_last on 01.
- num_words=4 with m_ready toggling 1,0,0,1,... -> byte sequence 08..0F intact; m_data held stable during stalls; total handshakes=8.
- num_words=0 -> done pulse, busy never high, m_valid never high; start pulsed during a busy run -> ignored, original run's byte count preserved.
- rst_n asserted low during the 3rd byte -> m_valid=0 and busy=0 immediately; a new run after release streams correctly from its new first_addr.
- ROM_SELFTEST_EN defined: corrupt the word at address 0x05 to 0xFFFF and stream 0x04..0x06 -> selftest_err rises after the 0x05 capture and stays high; bytes still emitted as read.
